vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- VGA raster timing generator and pixel output stage for the greedy-snake display path.
- Scans 640x480@60Hz and drives xpos/ypos into the graphics colour stage, which is combinational.
- Samples that stage's 12-bit colour and registers it with hsync/vsync so all VGA pins are phase-aligned.
- Emits a per-frame tick that game logic uses to update the snake state during vertical blanking.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock
rst  in  1  reset
pixel_in  in  12  colour from the graphics stage, {R[11:8],G[7:4],B[3:0]}
xpos  out  12  current column, combinational from hcount
ypos  out  9  current row, combinational from vcount
pix_tick  out  1  one-clk pulse, one per pixel period
video_on  out  1  registered active-video flag, aligned with RGB
hsync  out  1  registered, active-low
vsync  out  1  registered, active-low
vga_r  out  4  registered red
vga_g  out  4  registered green
vga_b  out  4  registered blue
frame_tick  out  1  one-clk pulse per frame at the start of vblank

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values:
  - div counter, hcount and vcount = 0.
  - vga_r, vga_g, vga_b = 0; video_on = 0; frame_tick = 0.
  - hsync = 1 and vsync = 1 (inactive).
  - pix_tick = 0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1), combinational.
  - With CLK_DIV=1, pix_tick is constant 1 once out of reset.
- Counters: only change on pix_tick.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 on that same tick.
  - Counter widths: 10 bits for hcount and vcount.
- Active region:
  - active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
  - Active pixels come first in each line and frame; porch and sync follow.
- xpos/ypos:
  - xpos = hcount zero-extended to 12 bits when hcount < H_ACTIVE, else 0.
  - ypos = vcount[8:0] when vcount < V_ACTIVE, else 0.
  - The graphics stage has the whole pixel period to settle.
- Output register, updated only on pix_tick from the current counts:
  - video_on <= active.
  - {vga_r,vga_g,vga_b} <= active ? pixel_in : 0.
  - hsync <= ~(hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]).
  - vsync <= ~(vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]).
  - Latency: exactly one pixel period from count to pins, identical for RGB, hsync, vsync and video_on.
- frame_tick:
  - Registered one-clk pulse, asserted the clk after a pix_tick on which hcount==H_TOTAL-1 and vcount==V_ACTIVE-1.
  - Exactly one pulse per frame.
- Reset mid-frame: all state returns to reset values immediately (asynchronous), including during sync pulses. After release, the scan restarts at (0,0) with div=0.
- pixel_in changes outside a pix_tick clk are ignored.

Test Plan:
- Reset check: assert rst mid-line with hsync low -> hsync=1, vsync=1, RGB=0, xpos=0, ypos=0 in the same cycle; after release, first pix_tick occurs 4 clks later.
- Line timing (defaults): measure hsync.
  - Falling edge period = 800 pix_ticks = 3200 clks.
  - Low width = 96 pix_ticks.
  - Falls on the pix_tick after hcount=656.
- Frame timing: measure vsync.
  - Low for 2 lines starting one pixel after (hcount=0, vcount=490).
  - Frame period = 525*800*4 = 1,680,000 clks.
  - frame_tick pulses once per frame, one clk after (799,479).
- Blanking: drive pixel_in=12'hFFF.
  - Exactly 307,200 pixel periods per frame have RGB=F,F,F.
  - video_on=1 on exactly those periods.
  - All other periods have RGB=0.
- Alignment: drive pixel_in = {xpos[3:0], ypos[3:0], 4'h5}.
  - Registered RGB at each pixel equals the value for the previous pix_tick's (xpos,ypos).
  - First visible pixel of a line = {0,row[3:0],5}.
- CLK_DIV=1 variant: pix_tick high every clk; line period = 800 clks; all other timing scales accordingly.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// Raster timing generator and registered VGA pin stage for the snake display.
// Counts produce xpos/ypos for the colour stage; its result is registered with the syncs.
module vga_scan_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_in,
  output logic [11:0] xpos,
  output logic [8:0]  ypos,
  output logic        pix_tick,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_tick
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W    = 10;

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             h_active;
  logic             v_active;
  logic             active;
  logic             h_end;
  logic             v_end;
  logic             hs_pulse;
  logic             vs_pulse;

  // Pixel-rate divider; the tick is masked while reset is held so it reads 0 then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_W'(CLK_DIV - 1)) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign pix_tick = ~rst & (div == DIV_W'(CLK_DIV - 1));

  assign h_end = (hcount == CNT_W'(H_TOTAL - 1));
  assign v_end = (vcount == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_tick) begin
      if (h_end) begin
        hcount <= '0;
        vcount <= v_end ? '0 : vcount + CNT_W'(1);
      end else begin
        hcount <= hcount + CNT_W'(1);
      end
    end
  end

  assign h_active = (hcount < CNT_W'(H_ACTIVE));
  assign v_active = (vcount < CNT_W'(V_ACTIVE));
  assign active   = h_active & v_active;
  assign hs_pulse = (hcount >= CNT_W'(HS_START)) && (hcount <= CNT_W'(HS_END));
  assign vs_pulse = (vcount >= CNT_W'(VS_START)) && (vcount <= CNT_W'(VS_END));

  assign xpos = h_active ? 12'(hcount) : 12'd0;
  assign ypos = v_active ? vcount[8:0] : 9'd0;

  // Pin stage: every VGA output sees the same one-pixel latency from the counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_on <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      vga_r    <= 4'd0;
      vga_g    <= 4'd0;
      vga_b    <= 4'd0;
    end else if (pix_tick) begin
      video_on              <= active;
      hsync                 <= ~hs_pulse;
      vsync                 <= ~vs_pulse;
      {vga_r, vga_g, vga_b} <= active ? pixel_in : 12'd0;
    end
  end

  // Start of vertical blanking: leaving the last pixel of the last visible line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_tick & h_end & (vcount == CNT_W'(V_ACTIVE - 1));
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: small raster geometry, two dividers, random pixel data
// compared every clock against a pixel-index model, plus hand-derived timing points.
module tb_vga_scan_ctrl;

  localparam int DIV1 = 2;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FRAME1 = HT * VT * DIV1;  // 720 clks

  typedef struct packed {
    logic [11:0] xpos;
    logic [8:0]  ypos;
    logic        pix_tick;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] pin1 = '0, pin2 = '0;
  logic [11:0] xpos1, xpos2;
  logic [8:0]  ypos1, ypos2;
  logic pix1, pix2, von1, von2, hs1, hs2, vs1, vs2, ft1, ft2;
  logic [3:0] r1, g1, b1, r2, g2, b2;

  always #5 clk = ~clk;

  vga_scan_ctrl #(.CLK_DIV(DIV1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut1 (
    .clk(clk), .rst(rst), .pixel_in(pin1), .xpos(xpos1), .ypos(ypos1), .pix_tick(pix1),
    .video_on(von1), .hsync(hs1), .vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .frame_tick(ft1));

  vga_scan_ctrl #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut2 (
    .clk(clk), .rst(rst), .pixel_in(pin2), .xpos(xpos2), .ypos(ypos2), .pix_tick(pix2),
    .video_on(von2), .hsync(hs2), .vsync(vs2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .frame_tick(ft2));

  int total = 0;
  int bad = 0;
  int k = 0;
  int mode = 0;
  logic [11:0] cap1 = '0, cap2 = '0;

  // Event measurements on the DUT pins, cleared per phase.
  int fall1_a, fall1_b, rise1_a, vsf1_a, ft1_a, ft1_cnt, von1_cnt, white1_cnt, pix1_a;
  int fall2_a, fall2_b, ft2_a;
  logic hs1_prev, hs2_prev, vs1_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Outputs after k clock edges since reset release: n pixel ticks have happened,
  // so the counts sit on pixel n and the pins show pixel n-1.
  function automatic obs_t model(input int kk, input int dv, input logic [11:0] cap);
    obs_t o;
    int n, h, v, ph, pv;
    n = kk / dv;
    h = n % HT;
    v = (n / HT) % VT;
    o.xpos = (h < HA) ? 12'(h) : 12'd0;
    o.ypos = (v < VA) ? 9'(v) : 9'd0;
    o.pix_tick = ((kk % dv) == dv - 1);
    if (n == 0) begin
      o.video_on = 1'b0; o.hsync = 1'b1; o.vsync = 1'b1; o.rgb = 12'd0; o.frame_tick = 1'b0;
    end else begin
      ph = (n - 1) % HT;
      pv = ((n - 1) / HT) % VT;
      o.video_on = (ph < HA) && (pv < VA);
      o.rgb = o.video_on ? cap : 12'd0;
      o.hsync = !((ph >= HA + HF) && (ph < HA + HF + HS));
      o.vsync = !((pv >= VA + VF) && (pv < VA + VF + VS));
      o.frame_tick = ((kk % dv) == 0) && (ph == HT - 1) && (pv == VA - 1);
    end
    return o;
  endfunction

  task automatic clear_ev();
    fall1_a = -1; fall1_b = -1; rise1_a = -1; vsf1_a = -1; ft1_a = -1; ft1_cnt = 0;
    von1_cnt = 0; white1_cnt = 0; pix1_a = -1; fall2_a = -1; fall2_b = -1; ft2_a = -1;
    hs1_prev = hs1; hs2_prev = hs2; vs1_prev = vs1;
  endtask

  task automatic step();
    obs_t e1, e2, a1, a2;
    @(posedge clk);
    #1;
    k++;
    if ((k % DIV1) == 0) cap1 = pin1;
    cap2 = pin2;
    e1 = model(k, DIV1, cap1);
    e2 = model(k, 1, cap2);
    a1 = {xpos1, ypos1, pix1, von1, hs1, vs1, r1, g1, b1, ft1};
    a2 = {xpos2, ypos2, pix2, von2, hs2, vs2, r2, g2, b2, ft2};
    chk("scan_div2", 64'(a1), 64'(e1));
    chk("scan_div1", 64'(a2), 64'(e2));
    if (hs1_prev && !hs1) begin
      if (fall1_a < 0) fall1_a = k; else if (fall1_b < 0) fall1_b = k;
    end
    if (!hs1_prev && hs1 && rise1_a < 0) rise1_a = k;
    if (vs1_prev && !vs1 && vsf1_a < 0) vsf1_a = k;
    if (hs2_prev && !hs2) begin
      if (fall2_a < 0) fall2_a = k; else if (fall2_b < 0) fall2_b = k;
    end
    if (ft1) begin ft1_cnt++; if (ft1_a < 0) ft1_a = k; end
    if (ft2 && ft2_a < 0) ft2_a = k;
    if (pix1 && pix1_a < 0) pix1_a = k;
    if (von1) von1_cnt++;
    if ({r1, g1, b1} == 12'hFFF) white1_cnt++;
    hs1_prev = hs1; hs2_prev = hs2; vs1_prev = vs1;
    case (mode)
      1:       pin1 = {e1.xpos[3:0], e1.ypos[3:0], 4'h5};
      2:       pin1 = 12'hFFF;
      default: pin1 = 12'($urandom);
    endcase
    pin2 = 12'($urandom);
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_sync1"}, 64'({hs1, vs1, pix1, von1, ft1}), 64'(5'b11000));
    chk({tag, "_rgb1"},  64'({r1, g1, b1}), 64'd0);
    chk({tag, "_pos1"},  64'({xpos1, ypos1}), 64'd0);
    chk({tag, "_sync2"}, 64'({hs2, vs2, pix2, von2, ft2}), 64'(5'b11000));
    chk({tag, "_rgb2"},  64'({r2, g2, b2, xpos2, ypos2}), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_pins("init");
    #3 rst = 1'b0;
    k = 0;
    mode = 0;
    clear_ev();

    // Three frames of random colour data.
    repeat (3 * FRAME1) step();
    chk("first_pix_tick", 64'(pix1_a), 64'd1);
    chk("hsync_fall", 64'(fall1_a), 64'd38);
    chk("hsync_low_width", 64'(rise1_a - fall1_a), 64'd6);
    chk("hsync_period", 64'(fall1_b - fall1_a), 64'd48);
    chk("vsync_fall", 64'(vsf1_a), 64'd482);
    chk("frame_tick_first", 64'(ft1_a), 64'd384);
    chk("frame_tick_count", 64'(ft1_cnt), 64'd3);
    chk("video_on_clks", 64'(von1_cnt), 64'd768);
    chk("div1_hsync_fall", 64'(fall2_a), 64'd19);
    chk("div1_line_period", 64'(fall2_b - fall2_a), 64'd24);
    chk("div1_frame_tick", 64'(ft2_a), 64'd192);

    // One frame of full-white input: only active pixels may show it.
    mode = 2;
    clear_ev();
    repeat (FRAME1) step();
    chk("white_clks", 64'(white1_cnt), 64'd256);
    chk("white_frame_ticks", 64'(ft1_cnt), 64'd1);

    // One frame with colour derived from the position it was generated for.
    mode = 1;
    repeat (FRAME1) step();

    // Asynchronous reset while hsync is in its pulse.
    mode = 0;
    begin
      int guard = 0;
      while (hs1 !== 1'b0 && guard < 200) begin step(); guard++; end
      if (guard >= 200) begin
        bad++; total++;
        $display("FAIL wait_hsync_low k=%0d actual=timeout required=hsync low", k);
      end
    end
    #2 rst = 1'b1;
    #1 chk_reset_pins("midrst");
    @(posedge clk);
    #1 chk_reset_pins("midrst_hold");
    #3 rst = 1'b0;
    k = 0;
    cap1 = '0; cap2 = '0;
    clear_ev();
    repeat (FRAME1) step();
    chk("rst_first_pix_tick", 64'(pix1_a), 64'd1);
    chk("rst_hsync_fall", 64'(fall1_a), 64'd38);
    chk("rst_frame_tick", 64'(ft1_a), 64'd384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
